bcd_updown_counter: RTL and testbench

Two-digit up/down BCD counter driven by the board push-buttons. It sits directly upstream of the per-digit seven-segment decoders. o_Tens and o_Ones each feed one decoder input, which accepts 0-9 and shows 0 for anything else. It owns all counting, wrap and clear policy, so the decoders stay purely combinational.

---
 rtl/bcd_updown_counter.sv | 232 +++++++++++++++++++++++
 tb/tb_bcd_updown_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - two-digit up/down BCD counter for push-button control
//
// Purpose:
//   Counts 0..MAX_VALUE in BCD on rising edges of the increment/decrement
//   buttons. It feeds per-digit seven-segment decoders directly, so every
//   presented digit is 0..9 and the value never exceeds MAX_VALUE.
//   Optional auto-repeat while a button is held: define BCD_COUNTER_AUTO_REPEAT_EN.
//
// Parameters:
//   MAX_VALUE      highest count reached, 1..99
//   WRAP           1 = wrap around at the limits, 0 = saturate
//   REPEAT_DELAY   hold cycles before auto-repeat starts (auto-repeat build only)
//   REPEAT_PERIOD  cycles between auto-repeat steps (auto-repeat build only)
//
// Ports:
//   i_Clk      system clock, rising edge
//   i_Rst      asynchronous active-high reset
//   i_Inc      increment button level (debounced, synchronous)
//   i_Dec      decrement button level (debounced, synchronous)
//   i_Clear    synchronous clear level
//   o_Tens     tens digit 0..9, zero-extended, registered
//   o_Ones     ones digit 0..9, zero-extended, registered
//   o_Count    binary value 10*o_Tens + o_Ones, registered
//   o_Changed  one-cycle pulse when the value changes
//   o_Wrap     one-cycle pulse on a wrap-around in either direction

module bcd_updown_counter #(
    parameter int MAX_VALUE     = 99,
    parameter int WRAP          = 1,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Inc,
    input  logic       i_Dec,
    input  logic       i_Clear,
    output logic [6:0] o_Tens,
    output logic [6:0] o_Ones,
    output logic [6:0] o_Count,
    output logic       o_Changed,
    output logic       o_Wrap
);

    // An illegal parameter set leaves the counter inert rather than letting it
    // present digits the decoders cannot show.
    localparam logic P_CFG_OK = (MAX_VALUE >= 1) && (MAX_VALUE <= 99) &&
                                (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

    localparam logic [6:0] P_MAX      = 7'(MAX_VALUE);
    localparam logic [3:0] P_MAX_TENS = 4'(MAX_VALUE / 10);
    localparam logic [3:0] P_MAX_ONES = 4'(MAX_VALUE % 10);
    localparam logic       P_WRAP     = (WRAP != 0);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic [6:0] r_count;
    logic       r_changed;
    logic       r_wrap;
    logic       r_inc_prev;
    logic       r_dec_prev;

    logic       w_up_evt;
    logic       w_dn_evt;
    logic       w_up_step;
    logic       w_dn_step;

    // Previous samples reset to 1 so a button held through reset release
    // is not mistaken for a fresh press.
    assign w_up_evt = i_Inc & ~r_inc_prev & P_CFG_OK;
    assign w_dn_evt = i_Dec & ~r_dec_prev & P_CFG_OK;

`ifdef BCD_COUNTER_AUTO_REPEAT_EN

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    localparam int P_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int P_CNT_W   = $clog2(P_RPT_MAX + 1);

    logic [1:0] w_btn;
    logic [1:0] w_evt;
    logic [1:0] w_rpt;
    logic       w_both;

    assign w_btn  = {i_Dec, i_Inc};
    assign w_evt  = {w_dn_evt, w_up_evt};
    assign w_both = i_Inc & i_Dec;

    // Index 0 is the increment direction, index 1 the decrement direction.
    for (genvar g = 0; g < 2; g++) begin : g_rpt
        rpt_state_t         r_state;
        rpt_state_t         w_state_nxt;
        logic [P_CNT_W-1:0] r_cnt;
        logic [P_CNT_W-1:0] w_cnt_nxt;
        logic               w_step;

        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // r_cnt holds the number of edges seen since the last step, so the
        // step fires exactly REPEAT_DELAY / REPEAT_PERIOD edges after it.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_step      = 1'b0;
            if (!w_btn[g] || w_both || i_Clear) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_evt[g]) begin
                            w_state_nxt = ST_DELAY;
                            w_cnt_nxt   = P_CNT_W'(1);
                        end
                    end
                    ST_DELAY: begin
                        if (r_cnt == P_CNT_W'(REPEAT_DELAY)) begin
                            w_step      = 1'b1;
                            w_state_nxt = ST_REPEAT;
                            w_cnt_nxt   = P_CNT_W'(1);
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_cnt == P_CNT_W'(REPEAT_PERIOD)) begin
                            w_step    = 1'b1;
                            w_cnt_nxt = P_CNT_W'(1);
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        assign w_rpt[g] = w_step;
    end

    assign w_up_step = w_up_evt | w_rpt[0];
    assign w_dn_step = w_dn_evt | w_rpt[1];

`else

    assign w_up_step = w_up_evt;
    assign w_dn_step = w_dn_evt;

`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_tens     <= '0;
            r_ones     <= '0;
            r_count    <= '0;
            r_changed  <= 1'b0;
            r_wrap     <= 1'b0;
            r_inc_prev <= 1'b1;
            r_dec_prev <= 1'b1;
        end else begin
            r_inc_prev <= i_Inc;
            r_dec_prev <= i_Dec;
            r_changed  <= 1'b0;
            r_wrap     <= 1'b0;

            if (i_Clear) begin
                r_tens    <= '0;
                r_ones    <= '0;
                r_count   <= '0;
                r_changed <= (r_count != 7'd0);
            end else if (w_up_step && w_dn_step) begin
                // Simultaneous opposite steps cancel.
            end else if (w_up_step) begin
                if (r_count < P_MAX) begin
                    if (r_ones == 4'd9) begin
                        r_ones <= 4'd0;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_ones <= r_ones + 4'd1;
                    end
                    r_count   <= r_count + 7'd1;
                    r_changed <= 1'b1;
                end else if (P_WRAP) begin
                    r_tens    <= '0;
                    r_ones    <= '0;
                    r_count   <= '0;
                    r_changed <= 1'b1;
                    r_wrap    <= 1'b1;
                end
            end else if (w_dn_step) begin
                if (r_count != 7'd0) begin
                    if (r_ones == 4'd0) begin
                        r_ones <= 4'd9;
                        r_tens <= r_tens - 4'd1;
                    end else begin
                        r_ones <= r_ones - 4'd1;
                    end
                    r_count   <= r_count - 7'd1;
                    r_changed <= 1'b1;
                end else if (P_WRAP) begin
                    r_tens    <= P_MAX_TENS;
                    r_ones    <= P_MAX_ONES;
                    r_count   <= P_MAX;
                    r_changed <= 1'b1;
                    r_wrap    <= 1'b1;
                end
            end
        end
    end

    assign o_Tens    = {3'b000, r_tens};
    assign o_Ones    = {3'b000, r_ones};
    assign o_Count   = r_count;
    assign o_Changed = r_changed;
    assign o_Wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - directed self-checking bench for bcd_updown_counter

module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inc [4];
    logic       dec [4];
    logic       clr [4];
    logic [6:0] tens [4];
    logic [6:0] ones [4];
    logic [6:0] cnt  [4];
    logic       chg  [4];
    logic       wrp  [4];

    int n_cmp = 0;
    int n_bad = 0;
    int n_chg [4] = '{0, 0, 0, 0};
    int n_wrp [4] = '{0, 0, 0, 0};

    int cap_cnt, cap_tens, cap_ones, cap_chg, cap_wrp;
    int steps;
    int step_at [8];

    always #5 clk = ~clk;

    // u0: defaults (99, wrap); u1: 59 with wrap; u2: 99 saturating; u3: short repeat timing
    bcd_updown_counter u0 (
        .i_Clk(clk), .i_Rst(rst), .i_Inc(inc[0]), .i_Dec(dec[0]), .i_Clear(clr[0]),
        .o_Tens(tens[0]), .o_Ones(ones[0]), .o_Count(cnt[0]), .o_Changed(chg[0]), .o_Wrap(wrp[0]));
    bcd_updown_counter #(.MAX_VALUE(59), .WRAP(1)) u1 (
        .i_Clk(clk), .i_Rst(rst), .i_Inc(inc[1]), .i_Dec(dec[1]), .i_Clear(clr[1]),
        .o_Tens(tens[1]), .o_Ones(ones[1]), .o_Count(cnt[1]), .o_Changed(chg[1]), .o_Wrap(wrp[1]));
    bcd_updown_counter #(.MAX_VALUE(99), .WRAP(0)) u2 (
        .i_Clk(clk), .i_Rst(rst), .i_Inc(inc[2]), .i_Dec(dec[2]), .i_Clear(clr[2]),
        .o_Tens(tens[2]), .o_Ones(ones[2]), .o_Count(cnt[2]), .o_Changed(chg[2]), .o_Wrap(wrp[2]));
    bcd_updown_counter #(.REPEAT_DELAY(8), .REPEAT_PERIOD(4)) u3 (
        .i_Clk(clk), .i_Rst(rst), .i_Inc(inc[3]), .i_Dec(dec[3]), .i_Clear(clr[3]),
        .o_Tens(tens[3]), .o_Ones(ones[3]), .o_Count(cnt[3]), .o_Changed(chg[3]), .o_Wrap(wrp[3]));

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (chg[d]) n_chg[d]++;
            if (wrp[d]) n_wrp[d]++;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle input pattern on DUT d; outputs captured just after the sampling edge.
    task automatic pulse(input int d, input bit i, input bit dn, input bit c);
        @(negedge clk);
        inc[d] = i; dec[d] = dn; clr[d] = c;
        @(posedge clk);
        #1;
        cap_cnt  = int'(cnt[d]);
        cap_tens = int'(tens[d]);
        cap_ones = int'(ones[d]);
        cap_chg  = int'(chg[d]);
        cap_wrp  = int'(wrp[d]);
        @(negedge clk);
        inc[d] = 1'b0; dec[d] = 1'b0; clr[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            inc[d] = 1'b0; dec[d] = 1'b0; clr[d] = 1'b0;
        end
        inc[0] = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_eq("reset_count", int'(cnt[0]), 0);
        check_eq("reset_tens", int'(tens[0]), 0);
        check_eq("reset_changed", int'(chg[0]), 0);
        check_eq("reset_wrap", int'(wrp[0]), 0);

        // Increment held through reset release must not count.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("held_thru_reset_count", int'(cnt[0]), 0);
        check_eq("held_thru_reset_changed", n_chg[0], 0);
        inc[0] = 1'b0;

        for (int k = 0; k < 10; k++) pulse(0, 1, 0, 0);
        repeat (2) @(negedge clk);
        check_eq("ten_inc_tens", int'(tens[0]), 1);
        check_eq("ten_inc_ones", int'(ones[0]), 0);
        check_eq("ten_inc_count", int'(cnt[0]), 10);
        check_eq("ten_inc_changed_pulses", n_chg[0], 10);
        check_eq("ten_inc_wrap_pulses", n_wrp[0], 0);

        pulse(0, 0, 1, 0);
        check_eq("borrow_count", cap_cnt, 9);
        check_eq("borrow_tens", cap_tens, 0);
        check_eq("borrow_ones", cap_ones, 9);
        check_eq("borrow_changed", cap_chg, 1);
        pulse(0, 1, 0, 0);
        check_eq("carry_count", cap_cnt, 10);
        check_eq("carry_tens", cap_tens, 1);

        for (int k = 0; k < 32; k++) pulse(0, 1, 0, 0);
        check_eq("reach_42", cap_cnt, 42);
        pulse(0, 1, 1, 0);
        check_eq("cancel_count", cap_cnt, 42);
        check_eq("cancel_changed", cap_chg, 0);
        check_eq("cancel_wrap", cap_wrp, 0);
        pulse(0, 1, 0, 1);
        check_eq("clear_inc_count", cap_cnt, 0);
        check_eq("clear_inc_changed", cap_chg, 1);
        check_eq("clear_inc_wrap", cap_wrp, 0);
        pulse(0, 0, 0, 1);
        check_eq("clear_at_zero_changed", cap_chg, 0);

        pulse(1, 0, 1, 0);
        check_eq("m59_dec_wrap_count", cap_cnt, 59);
        check_eq("m59_dec_wrap_tens", cap_tens, 5);
        check_eq("m59_dec_wrap_ones", cap_ones, 9);
        check_eq("m59_dec_wrap_pulse", cap_wrp, 1);
        pulse(1, 1, 0, 0);
        check_eq("m59_inc_wrap_count", cap_cnt, 0);
        check_eq("m59_inc_wrap_pulse", cap_wrp, 1);
        check_eq("m59_inc_wrap_changed", cap_chg, 1);
        @(posedge clk);
        #1;
        check_eq("m59_wrap_one_cycle", int'(wrp[1]), 0);
        pulse(1, 0, 1, 0);
        check_eq("m59_dec_again_count", cap_cnt, 59);
        check_eq("m59_dec_again_wrap", cap_wrp, 1);

        pulse(2, 0, 1, 0);
        check_eq("sat_low_count", cap_cnt, 0);
        check_eq("sat_low_changed", cap_chg, 0);
        check_eq("sat_low_wrap", cap_wrp, 0);
        for (int k = 0; k < 99; k++) pulse(2, 1, 0, 0);
        check_eq("reach_99_count", cap_cnt, 99);
        check_eq("reach_99_tens", cap_tens, 9);
        check_eq("reach_99_ones", cap_ones, 9);
        pulse(2, 1, 0, 0);
        check_eq("sat_high_count", cap_cnt, 99);
        check_eq("sat_high_changed", cap_chg, 0);
        check_eq("sat_high_wrap", cap_wrp, 0);

        // Hold increment for 20 edges on u3 and note which edges stepped.
        steps = 0;
        @(negedge clk);
        inc[3] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (chg[3]) begin
                if (steps < 8) step_at[steps] = k;
                steps++;
            end
        end
        @(negedge clk);
        inc[3] = 1'b0;
`ifdef BCD_COUNTER_AUTO_REPEAT_EN
        check_eq("hold_steps", steps, 4);
        check_eq("hold_step0", step_at[0], 0);
        check_eq("hold_step1", step_at[1], 8);
        check_eq("hold_step2", step_at[2], 12);
        check_eq("hold_step3", step_at[3], 16);
        check_eq("hold_final", int'(cnt[3]), 4);
`else
        check_eq("hold_steps", steps, 1);
        check_eq("hold_step0", step_at[0], 0);
        check_eq("hold_final", int'(cnt[3]), 1);
`endif

        // Reset in the middle of a hold; the still-held button must not step afterwards.
        @(negedge clk);
        inc[3] = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_hold_reset_count", int'(cnt[3]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_eq("after_hold_reset_count", int'(cnt[3]), 0);
        @(negedge clk);
        inc[3] = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
